// File: rtl/aes_128_pkg.sv
// aes_128_pkg: shared AES-128 key-schedule constants, FSM states and word helpers.
package aes_128_pkg;

    localparam int NUM_RKEYS = 11;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic {IDLE, EXPAND} state_e;

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // w0 takes the SubWord/RCON term; each later word chains off the one before it.
    function automatic logic [127:0] xor_chain(input logic [127:0] k, input logic [31:0] t);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_128_sbox.sv
// aes_128_sbox: combinational AES forward S-box, shared by key expansion and SubBytes.
(* keep_hierarchy = "yes" *)
module aes_128_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so the MSB of entry n is 2047 - 8n.
    assign out_o = SBOX[{~in_i, 3'b111} -: 8];

endmodule

// File: rtl/aes_128_key_expand.sv
// aes_128_key_expand: iterative AES-128 key schedule streaming round keys 0..10 to the key store.
module aes_128_key_expand
    import aes_128_pkg::*;
(
    input  logic         clk,
    input  logic         kill,
    input  logic         key_start,
    input  logic [127:0] key_in,
    output logic         key_busy,
    output logic         en_wr,
    output logic [127:0] key_round_wr,
    output logic         key_loaded
);

    state_e       state_q;
    logic [3:0]   rnd_q;
    logic [127:0] key_q, key_d;
    logic         en_wr_q, key_loaded_q;
    logic [31:0]  rot_w, sub_w;

    assign rot_w = rot_word(key_q[31:0]);

    for (genvar i = 0; i < 4; i++) begin : g_sub
        aes_128_sbox u_sbox (.in_i(rot_w[8*i +: 8]), .out_o(sub_w[8*i +: 8]));
    end

    // RCON index runs one ahead of rnd; the value formed at rnd==10 is never stored.
    assign key_d = xor_chain(key_q, sub_w ^ {RCON[rnd_q + 4'd1], 24'h0});

    always_ff @(posedge clk or posedge kill) begin
        if (kill) begin
            state_q      <= IDLE;
            rnd_q        <= '0;
            key_q        <= '0;
            en_wr_q      <= 1'b0;
            key_loaded_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (key_start) begin
                state_q      <= EXPAND;
                key_q        <= key_in;
                rnd_q        <= '0;
                en_wr_q      <= 1'b1;
                key_loaded_q <= 1'b0;
            end
        end else if (rnd_q == 4'(NUM_RKEYS - 1)) begin
            state_q      <= IDLE;
            en_wr_q      <= 1'b0;
            key_loaded_q <= 1'b1;
        end else begin
            key_q <= key_d;
            rnd_q <= rnd_q + 4'd1;
        end
    end

    assign en_wr        = en_wr_q;
    assign key_busy     = en_wr_q;
    assign key_round_wr = key_q;
    assign key_loaded   = key_loaded_q;

endmodule

// File: tb/tb_aes_128_key_expand.sv
// tb_aes_128_key_expand: scoreboard bench; expected round keys come from an independent GF(2^8) model.
module tb_aes_128_key_expand;

    logic         clk = 1'b0;
    logic         kill;
    logic         key_start;
    logic [127:0] key_in;
    logic         key_busy, en_wr, key_loaded;
    logic [127:0] key_round_wr;

    localparam logic [127:0] A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic [127:0] exp_q[$];
    logic [127:0] wlog [0:255];
    int           wcnt = 0;
    int           npass = 0;
    int           ntot = 0;
    int           base, snap;

    aes_128_key_expand dut (
        .clk(clk), .kill(kill), .key_start(key_start), .key_in(key_in),
        .key_busy(key_busy), .en_wr(en_wr), .key_round_wr(key_round_wr), .key_loaded(key_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] v = 8'h00;
        for (int y = 1; y < 256; y++)
            if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) v = 8'(y);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] nxt(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sb(k[23:16]), sb(k[15:8]), sb(k[7:0]), sb(k[31:24])} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    task automatic push_keys(input logic [127:0] key);
        logic [127:0] k = key;
        logic [7:0]   rc = 8'h01;
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back(k);
            k  = nxt(k, rc);
            rc = xt(rc);
        end
    endtask

    always @(negedge clk) begin
        if (en_wr === 1'b1) begin
            wlog[wcnt[7:0]] = key_round_wr;
            wcnt++;
            if (exp_q.size() == 0) chk("unexpected_write", key_round_wr, 128'h0 ^ {128{1'bx}});
            else chk("round_key", key_round_wr, exp_q.pop_front());
        end
    end

    task automatic burst(input logic [127:0] key, input string tag);
        key_in    = key;
        key_start = 1'b1;
        base      = wcnt;
        push_keys(key);
        @(negedge clk);
        key_start = 1'b0;
        chk({tag, "_loaded_clr"}, 128'(key_loaded), 128'd0);
        repeat (10) @(negedge clk);
        chk({tag, "_busy_last"}, 128'(key_busy), 128'd1);
        @(negedge clk);
        chk({tag, "_loaded"}, 128'(key_loaded), 128'd1);
        chk({tag, "_en_done"}, 128'(en_wr), 128'd0);
        chk({tag, "_busy_done"}, 128'(key_busy), 128'd0);
        chk({tag, "_nwrites"}, 128'(wcnt - base), 128'd11);
        chk({tag, "_queue_empty"}, 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        kill      = 1'b1;
        key_start = 1'b0;
        key_in    = '0;
        repeat (2) @(negedge clk);
        chk("rst_en_wr", 128'(en_wr), 128'd0);
        chk("rst_key_round_wr", key_round_wr, 128'd0);
        chk("rst_busy", 128'(key_busy), 128'd0);
        chk("rst_loaded", 128'(key_loaded), 128'd0);
        kill = 1'b0;
        @(negedge clk);

        burst(A1_KEY, "a1");
        chk("a1_w0", wlog[base[7:0]], A1_KEY);
        chk("a1_w1", wlog[8'(base + 1)], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("a1_w10", wlog[8'(base + 10)], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        burst(128'h0, "zero");
        chk("zero_w1", wlog[8'(base + 1)], 128'h62636363626363636263636362636363);
        chk("zero_w2", wlog[8'(base + 2)], 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);
        chk("zero_w10", wlog[8'(base + 10)], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // start pulse with a zero key during write 4 must be ignored
        key_in    = A1_KEY;
        key_start = 1'b1;
        base      = wcnt;
        push_keys(A1_KEY);
        @(negedge clk);
        key_start = 1'b0;
        repeat (4) @(negedge clk);
        key_in    = '0;
        key_start = 1'b1;
        @(negedge clk);
        key_start = 1'b0;
        repeat (9) @(negedge clk);
        chk("ign_nwrites", 128'(wcnt - base), 128'd11);
        chk("ign_queue_empty", 128'(exp_q.size()), 128'd0);
        chk("ign_loaded", 128'(key_loaded), 128'd1);
        chk("ign_w10", wlog[8'(base + 10)], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // kill in the middle of write 5
        key_in    = A1_KEY;
        key_start = 1'b1;
        push_keys(A1_KEY);
        @(negedge clk);
        key_start = 1'b0;
        repeat (5) @(negedge clk);
        #2 kill = 1'b1;
        #1;
        chk("kill_en_wr", 128'(en_wr), 128'd0);
        chk("kill_key_round_wr", key_round_wr, 128'd0);
        chk("kill_busy", 128'(key_busy), 128'd0);
        chk("kill_loaded", 128'(key_loaded), 128'd0);
        exp_q.delete();
        snap = wcnt;
        repeat (2) @(negedge clk);
        kill = 1'b0;
        repeat (2) @(negedge clk);
        chk("kill_no_writes", 128'(wcnt - snap), 128'd0);
        burst(A1_KEY, "post_kill");
        chk("post_kill_w10", wlog[8'(base + 10)], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // key_start held high: 12-cycle period, one gap cycle with key_loaded set
        key_in    = A1_KEY;
        key_start = 1'b1;
        base      = wcnt;
        for (int b = 0; b < 3; b++) push_keys(A1_KEY);
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            if (c == 30) key_start = 1'b0;
            chk($sformatf("held_en_c%0d", c), 128'(en_wr), 128'(((c - 1) % 12) != 11));
            chk($sformatf("held_loaded_c%0d", c), 128'(key_loaded), 128'(((c - 1) % 12) == 11));
        end
        chk("held_nwrites", 128'(wcnt - base), 128'd33);
        chk("held_queue_empty", 128'(exp_q.size()), 128'd0);

        // key_in churns every cycle after the accept edge
        key_in    = {$urandom, $urandom, $urandom, $urandom};
        key_start = 1'b1;
        base      = wcnt;
        push_keys(key_in);
        @(negedge clk);
        key_start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            key_in = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
        end
        chk("churn_nwrites", 128'(wcnt - base), 128'd11);
        chk("churn_queue_empty", 128'(exp_q.size()), 128'd0);
        chk("churn_loaded", 128'(key_loaded), 128'd1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
